// File: rtl/mig_app_responder.sv
// Behavioural stand-in for a MIG user interface: calibration delay,
// write-data FIFO, small byte-maskable memory and fixed-latency reads.
module mig_app_responder #(
    parameter int ADDR_LSB     = 3,
    parameter int MEM_AW       = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LATENCY   = 4,
    parameter int WDF_DEPTH    = 4
) (
    input  logic         ui_clk,
    input  logic         ui_clk_sync_rst,
    input  logic [27:0]  app_addr,
    input  logic [2:0]   app_cmd,
    input  logic         app_en,
    output logic         app_rdy,
    input  logic [127:0] app_wdf_data,
    input  logic [15:0]  app_wdf_mask,
    input  logic         app_wdf_wren,
    input  logic         app_wdf_end,
    output logic         app_wdf_rdy,
    output logic [127:0] app_rd_data,
    output logic         app_rd_data_valid,
    output logic         app_rd_data_end,
    input  logic         app_ref_req,
    output logic         app_ref_ack,
    input  logic         app_zq_req,
    output logic         app_zq_ack,
    output logic         init_calib_complete,
    output logic         cmd_err
);

    localparam int WORDS = 1 << MEM_AW;
    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam int PW    = (WDF_DEPTH > 1) ? $clog2(WDF_DEPTH) : 1;
    localparam int FW    = $clog2(WDF_DEPTH + 1);

    typedef enum logic [1:0] {CALIB, IDLE, WAIT_WDATA} state_t;

    state_t            state;
    logic [CW-1:0]     calib_cnt;
    logic [127:0]      mem [WORDS];
    logic [143:0]      fifo [WDF_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [FW-1:0]     count;
    logic [MEM_AW-1:0] idx, wait_idx, commit_idx;
    logic [143:0]      head;
    logic [RD_LATENCY-1:0] pv;
    logic [127:0]      pd [RD_LATENCY];
    logic cmd_acc, wr_acc, rd_acc, nop_acc;
    logic push, pop, fifo_empty;
    logic unused_addr;

    assign idx         = app_addr[ADDR_LSB+MEM_AW-1:ADDR_LSB];
    assign unused_addr = ^app_addr;
    assign app_rdy     = (state == IDLE);
    assign app_wdf_rdy = init_calib_complete && (count != FW'(WDF_DEPTH));
    assign fifo_empty  = (count == '0);
    assign cmd_acc     = app_en && app_rdy;
    assign wr_acc      = cmd_acc && (app_cmd == 3'b000);
    assign rd_acc      = cmd_acc && (app_cmd == 3'b001);
    assign nop_acc     = cmd_acc && !wr_acc && !rd_acc;
    assign push        = app_wdf_wren && app_wdf_rdy;
    assign pop         = (wr_acc || state == WAIT_WDATA) && !fifo_empty;
    assign commit_idx  = (state == WAIT_WDATA) ? wait_idx : idx;
    assign head        = fifo[rd_ptr];

    assign app_rd_data_valid = pv[RD_LATENCY-1];
    assign app_rd_data_end   = pv[RD_LATENCY-1];
    assign app_rd_data       = pd[RD_LATENCY-1];

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state               <= CALIB;
            calib_cnt           <= '0;
            init_calib_complete <= 1'b0;
            wait_idx            <= '0;
        end else begin
            if (!init_calib_complete) calib_cnt <= calib_cnt + CW'(1);
            unique case (state)
                CALIB: if (calib_cnt == CW'(CALIB_CYCLES - 1)) begin
                    state               <= IDLE;
                    init_calib_complete <= 1'b1;
                end
                IDLE: if (wr_acc && fifo_empty) begin
                    state    <= WAIT_WDATA;
                    wait_idx <= idx;
                end
                WAIT_WDATA: if (!fifo_empty) state <= IDLE;
                default: state <= CALIB;
            endcase
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths stay correct.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < WDF_DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= {app_wdf_data, app_wdf_mask};
                wr_ptr <= (wr_ptr == PW'(WDF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(WDF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)      count <= count + FW'(1);
            else if (pop && !push) count <= count - FW'(1);
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            for (int w = 0; w < WORDS; w++) mem[w] <= '0;
        end else if (pop) begin
            for (int b = 0; b < 16; b++)
                if (!head[b]) mem[commit_idx][8*b +: 8] <= head[16 + 8*b +: 8];
        end
    end

    // Each stage loads data only with its valid, so the output holds.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            pv <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
        end else begin
            pv[0] <= rd_acc;
            if (rd_acc) pd[0] <= mem[idx];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            cmd_err     <= 1'b0;
            app_ref_ack <= 1'b0;
            app_zq_ack  <= 1'b0;
        end else begin
            cmd_err     <= nop_acc || (push && !app_wdf_end);
            app_ref_ack <= app_ref_req && init_calib_complete;
            app_zq_ack  <= app_zq_req && init_calib_complete;
        end
    end

endmodule
